wb_arb_dec: RTL and testbench

- Wishbone interconnect core between the two bus masters (CPU MMU port, disk DMA master port) and the three slaves (main memory, DMA register slave, keyboard).
- Arbitrates between the two masters with round-robin fairness and holds one transfer in flight at a time.
- Decodes the captured address to one slave and returns that slave's ack and read data to the granted master.
- Terminates unmapped or hung accesses with an error ack so neither master can deadlock the bus.

---
 rtl/wb_pkg.sv | 47 ++++
 rtl/wb_arb_dec_if.sv | 18 +
 rtl/wb_rr_arb.sv | 40 ++++
 rtl/wb_arb_dec.sv | 198 +++++++++++++++++++
 tb/tb_wb_arb_dec.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the Wishbone arbiter/decoder: FSM state encoding,
// one-hot slave select, default address map, error read data and the
// address decode helper.
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_ERR    = 2'd2
    } wb_state_e;

    typedef enum logic [2:0] {
        SEL_NONE = 3'b000,
        SEL_MEM  = 3'b001,
        SEL_DMA  = 3'b010,
        SEL_KEY  = 3'b100
    } wb_sel_e;

    localparam logic [31:0] MEM_MASK_DEF = 32'hFFFF_8000;
    localparam logic [31:0] MEM_BASE_DEF = 32'h0000_0000;
    localparam logic [31:0] DMA_MASK_DEF = 32'hFFFF_FF00;
    localparam logic [31:0] DMA_BASE_DEF = 32'h0001_0000;
    localparam logic [31:0] KEY_MASK_DEF = 32'hFFFF_FFF0;
    localparam logic [31:0] KEY_BASE_DEF = 32'h0001_0100;
    localparam int unsigned TIMEOUT_CYC_DEF = 64;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Overlapping windows resolve in the order MEM > DMA > KEY.
    function automatic wb_sel_e wb_decode(
        input logic [31:0] addr,
        input logic [31:0] mem_mask,
        input logic [31:0] mem_base,
        input logic [31:0] dma_mask,
        input logic [31:0] dma_base,
        input logic [31:0] key_mask,
        input logic [31:0] key_base
    );
        if ((addr & mem_mask) == mem_base) return SEL_MEM;
        if ((addr & dma_mask) == dma_base) return SEL_DMA;
        if ((addr & key_mask) == key_base) return SEL_KEY;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/wb_arb_dec_if.sv
// -----------------------------------------------------------------------------
// wb_arb_dec_if
// One classic Wishbone point-to-point link.
//   master modport : drives cyc/we/strb/addr/wdata, receives ack/rdata
//   slave  modport : receives cyc/we/strb/addr/wdata, drives ack/rdata
// -----------------------------------------------------------------------------
interface wb_arb_dec_if;
    logic        cyc;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output cyc, we, strb, addr, wdata, input ack, rdata);
    modport slave  (input cyc, we, strb, addr, wdata, output ack, rdata);
endinterface

// File: rtl/wb_rr_arb.sv
// -----------------------------------------------------------------------------
// wb_rr_arb
// Two-requester round-robin picker.
//   clk, rst_n : clock, synchronous active-low reset
//   req_i[1:0] : requests (bit 0 = MMU, bit 1 = DMA)
//   upd_i      : a grant is being taken this cycle, advance the pointer
//   gnt_o[1:0] : one-hot grant (combinational)
// -----------------------------------------------------------------------------
module wb_rr_arb
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic [1:0] gnt_o
);

    // 1 = requester 1 (DMA) was granted last. Resets to 0 so DMA wins the first tie.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else if (upd_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

// File: rtl/wb_arb_dec.sv
// -----------------------------------------------------------------------------
// wb_arb_dec
// Wishbone interconnect: two masters (MMU, DMA) to three slaves (memory,
// DMA registers, keyboard). Round-robin arbitration, one transfer in flight,
// registered one-hot address decode, error termination for unmapped or
// timed-out accesses.
//   clk, rst_n      : clock, synchronous active-low reset
//   m_mmu, m_dma    : master links (slave modport)
//   s_mem/s_dma/s_key : slave links (master modport)
//   bus_err         : one-cycle pulse during an error termination
//   err_addr        : address of the most recent error termination
//
// state  | meaning
// IDLE   | no transfer, arbitrate and capture request
// ACTIVE | selected slave cyc asserted, waiting for ack or timeout
// ERR    | one-cycle error ack to granted master
// -----------------------------------------------------------------------------
module wb_arb_dec
    import wb_pkg::*;
#(
    parameter logic [31:0] MEM_MASK    = MEM_MASK_DEF,
    parameter logic [31:0] MEM_BASE    = MEM_BASE_DEF,
    parameter logic [31:0] DMA_MASK    = DMA_MASK_DEF,
    parameter logic [31:0] DMA_BASE    = DMA_BASE_DEF,
    parameter logic [31:0] KEY_MASK    = KEY_MASK_DEF,
    parameter logic [31:0] KEY_BASE    = KEY_BASE_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arb_dec_if.slave  m_mmu,
    wb_arb_dec_if.slave  m_dma,
    wb_arb_dec_if.master s_mem,
    wb_arb_dec_if.master s_dma,
    wb_arb_dec_if.master s_key,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam logic [6:0] TMO_LAST = 7'(TIMEOUT_CYC - 1);

    wb_state_e   state_q;
    wb_sel_e     sel_q;
    logic        gid_q;      // 0 = MMU, 1 = DMA
    logic        we_q;
    logic [3:0]  strb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [6:0]  tmo_q;
    logic        bus_err_q;
    logic [31:0] err_addr_q;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        arb_upd;
    logic        req_we;
    logic [3:0]  req_strb;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    wb_sel_e     dec_sel;

    logic        active;
    logic        err;
    logic        s_ack_sel;
    logic [31:0] s_rdata_sel;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        cyc_mem, cyc_dma, cyc_key;

    assign req     = {m_dma.cyc, m_mmu.cyc};
    assign arb_upd = (state_q == ST_IDLE) && (req != 2'b00);

    wb_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .upd_i (arb_upd),
        .gnt_o (gnt)
    );

    always_comb begin
        if (gnt[0]) begin
            req_we    = m_mmu.we;
            req_strb  = m_mmu.strb;
            req_addr  = m_mmu.addr;
            req_wdata = m_mmu.wdata;
        end else begin
            req_we    = m_dma.we;
            req_strb  = m_dma.strb;
            req_addr  = m_dma.addr;
            req_wdata = m_dma.wdata;
        end
    end

    assign dec_sel = wb_decode(req_addr, MEM_MASK, MEM_BASE, DMA_MASK, DMA_BASE,
                               KEY_MASK, KEY_BASE);

    always_comb begin
        s_ack_sel   = 1'b0;
        s_rdata_sel = '0;
        case (sel_q)
            SEL_MEM: begin s_ack_sel = s_mem.ack; s_rdata_sel = s_mem.rdata; end
            SEL_DMA: begin s_ack_sel = s_dma.ack; s_rdata_sel = s_dma.rdata; end
            SEL_KEY: begin s_ack_sel = s_key.ack; s_rdata_sel = s_key.rdata; end
            default: begin s_ack_sel = 1'b0;      s_rdata_sel = '0;          end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_NONE;
            gid_q      <= 1'b0;
            we_q       <= 1'b0;
            strb_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tmo_q      <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            bus_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        gid_q   <= gnt[1];
                        we_q    <= req_we;
                        strb_q  <= req_strb;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        sel_q   <= dec_sel;
                        tmo_q   <= '0;
                        if (dec_sel == SEL_NONE) begin
                            state_q    <= ST_ERR;
                            bus_err_q  <= 1'b1;
                            err_addr_q <= req_addr;
                        end else begin
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    // An ack on the final count cycle beats the timeout.
                    if (s_ack_sel) begin
                        state_q <= ST_IDLE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q    <= ST_ERR;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                    end else begin
                        tmo_q <= tmo_q + 7'd1;
                    end
                end
                ST_ERR:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign active = (state_q == ST_ACTIVE);
    assign err    = (state_q == ST_ERR);

    assign cyc_mem = active && (sel_q == SEL_MEM);
    assign cyc_dma = active && (sel_q == SEL_DMA);
    assign cyc_key = active && (sel_q == SEL_KEY);

    assign s_mem.cyc   = cyc_mem;
    assign s_mem.we    = cyc_mem & we_q;
    assign s_mem.strb  = cyc_mem ? strb_q  : '0;
    assign s_mem.addr  = cyc_mem ? addr_q  : '0;
    assign s_mem.wdata = cyc_mem ? wdata_q : '0;

    assign s_dma.cyc   = cyc_dma;
    assign s_dma.we    = cyc_dma & we_q;
    assign s_dma.strb  = cyc_dma ? strb_q  : '0;
    assign s_dma.addr  = cyc_dma ? addr_q  : '0;
    assign s_dma.wdata = cyc_dma ? wdata_q : '0;

    assign s_key.cyc   = cyc_key;
    assign s_key.we    = cyc_key & we_q;
    assign s_key.strb  = cyc_key ? strb_q  : '0;
    assign s_key.addr  = cyc_key ? addr_q  : '0;
    assign s_key.wdata = cyc_key ? wdata_q : '0;

    // Slave response goes straight through to the granted master.
    assign m_ack   = (active && s_ack_sel) || err;
    assign m_rdata = err ? ERR_DATA : (active ? s_rdata_sel : '0);

    assign m_mmu.ack   = m_ack && !gid_q;
    assign m_mmu.rdata = !gid_q ? m_rdata : '0;
    assign m_dma.ack   = m_ack && gid_q;
    assign m_dma.rdata = gid_q ? m_rdata : '0;

    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_wb_arb_dec.sv
module tb_wb_arb_dec;
    logic        clk;
    logic        rst_n;
    logic        bus_err;
    logic [31:0] err_addr;
    int          n_chk;
    int          n_pass;
    int          n_cyc;

    wb_arb_dec_if m_mmu ();
    wb_arb_dec_if m_dma ();
    wb_arb_dec_if s_mem ();
    wb_arb_dec_if s_dma ();
    wb_arb_dec_if s_key ();

    wb_arb_dec dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_mmu    (m_mmu),
        .m_dma    (m_dma),
        .s_mem    (s_mem),
        .s_dma    (s_dma),
        .s_key    (s_key),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        m_mmu.cyc = 0; m_mmu.we = 0; m_mmu.strb = 0; m_mmu.addr = 0; m_mmu.wdata = 0;
        m_dma.cyc = 0; m_dma.we = 0; m_dma.strb = 0; m_dma.addr = 0; m_dma.wdata = 0;
        s_mem.ack = 0; s_mem.rdata = 0;
        s_dma.ack = 0; s_dma.rdata = 0;
        s_key.ack = 0; s_key.rdata = 0;

        // reset state
        tick(); tick();
        chk("rst_scyc", {29'd0, s_mem.cyc, s_dma.cyc, s_key.cyc}, 32'd0);
        chk("rst_mack", {30'd0, m_mmu.ack, m_dma.ack}, 32'd0);
        chk("rst_mdata", m_mmu.rdata | m_dma.rdata, 32'd0);
        chk("rst_buserr", {31'd0, bus_err}, 32'd0);
        chk("rst_erraddr", err_addr, 32'd0);
        rst_n = 1'b1;

        // MMU read from memory, memory acks on its 2nd cycle
        tick();
        m_mmu.cyc = 1; m_mmu.we = 0; m_mmu.strb = 4'hF; m_mmu.addr = 32'h0000_0040;
        #1;
        chk("t1_no_cyc_yet", {31'd0, s_mem.cyc}, 32'd0);
        tick();
        s_key.ack = 1; s_key.rdata = 32'h5555_5555;
        #1;
        chk("t1_mem_cyc", {31'd0, s_mem.cyc}, 32'd1);
        chk("t1_mem_addr", s_mem.addr, 32'h0000_0040);
        chk("t1_mem_we", {31'd0, s_mem.we}, 32'd0);
        chk("t1_foreign_ack", {31'd0, m_mmu.ack}, 32'd0);
        s_key.ack = 0;
        tick();
        s_mem.ack = 1; s_mem.rdata = 32'hCAFE_0001;
        #1;
        chk("t1_mmu_ack", {31'd0, m_mmu.ack}, 32'd1);
        chk("t1_mmu_data", m_mmu.rdata, 32'hCAFE_0001);
        chk("t1_dma_idle", {m_dma.ack, m_dma.rdata[30:0]}, 32'd0);
        tick();
        m_mmu.cyc = 0; s_mem.ack = 0;
        #1;
        chk("t1_mem_cyc_drop", {31'd0, s_mem.cyc}, 32'd0);
        chk("t1_ack_pulse", {31'd0, m_mmu.ack}, 32'd0);

        // DMA write to keyboard window
        m_dma.cyc = 1; m_dma.we = 1; m_dma.strb = 4'b0011;
        m_dma.addr = 32'h0001_0104; m_dma.wdata = 32'h1234_5678;
        tick();
        chk("t3_key_cyc", {29'd0, s_mem.cyc, s_dma.cyc, s_key.cyc}, 32'd1);
        chk("t3_key_we", {31'd0, s_key.we}, 32'd1);
        chk("t3_key_strb", {28'd0, s_key.strb}, 32'd3);
        chk("t3_key_addr", s_key.addr, 32'h0001_0104);
        chk("t3_key_data", s_key.wdata, 32'h1234_5678);
        s_key.ack = 1;
        #1;
        chk("t3_ack", {30'd0, m_dma.ack, m_mmu.ack}, 32'd2);
        tick();
        m_dma.cyc = 0; m_dma.we = 0; m_dma.strb = 0; s_key.ack = 0;

        // unmapped MMU read -> error termination
        m_mmu.cyc = 1; m_mmu.addr = 32'h0002_0000;
        #1;
        chk("t4_no_ack_yet", {31'd0, m_mmu.ack}, 32'd0);
        tick();
        chk("t4_err_ack", {31'd0, m_mmu.ack}, 32'd1);
        chk("t4_err_data", m_mmu.rdata, 32'hDEAD_BEEF);
        chk("t4_bus_err", {31'd0, bus_err}, 32'd1);
        chk("t4_err_addr", err_addr, 32'h0002_0000);
        chk("t4_no_scyc", {29'd0, s_mem.cyc, s_dma.cyc, s_key.cyc}, 32'd0);
        tick();
        m_mmu.cyc = 0;
        #1;
        chk("t4_err_pulse", {30'd0, bus_err, m_mmu.ack}, 32'd0);

        // keyboard never acks -> timeout after 64 cycles
        m_mmu.cyc = 1; m_mmu.addr = 32'h0001_0100;
        tick();
        n_cyc = 0;
        while (s_key.cyc === 1'b1 && n_cyc < 200) begin
            n_cyc++;
            tick();
        end
        chk("t5_tmo_len", n_cyc, 32'd64);
        chk("t5_tmo_ack", {31'd0, m_mmu.ack}, 32'd1);
        chk("t5_tmo_data", m_mmu.rdata, 32'hDEAD_BEEF);
        chk("t5_tmo_buserr", {31'd0, bus_err}, 32'd1);
        chk("t5_tmo_addr", err_addr, 32'h0001_0100);
        tick();
        m_mmu.cyc = 0;

        // ack on the final count cycle wins over the timeout
        m_mmu.cyc = 1; m_mmu.addr = 32'h0001_0104;
        tick();
        repeat (63) tick();
        chk("t5b_still_cyc", {31'd0, s_key.cyc}, 32'd1);
        s_key.ack = 1; s_key.rdata = 32'h0000_00AB;
        #1;
        chk("t5b_ack", {31'd0, m_mmu.ack}, 32'd1);
        chk("t5b_data", m_mmu.rdata, 32'h0000_00AB);
        tick();
        m_mmu.cyc = 0; s_key.ack = 0;
        #1;
        chk("t5b_no_err", {29'd0, bus_err, m_mmu.ack, s_key.cyc}, 32'd0);
        chk("t5b_erraddr_kept", err_addr, 32'h0001_0100);

        // round robin: both request, 4 transfers each
        m_mmu.cyc = 1; m_mmu.addr = 32'h0000_0100;
        m_dma.cyc = 1; m_dma.addr = 32'h0000_0200;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_cyc", {31'd0, s_mem.cyc}, 32'd1);
            chk("rr_addr", s_mem.addr, (i % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
            s_mem.ack = 1; s_mem.rdata = i;
            #1;
            chk("rr_ack", {30'd0, m_dma.ack, m_mmu.ack}, (i % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            s_mem.ack = 0;
            if (i == 6) m_dma.cyc = 0;
            if (i == 7) m_mmu.cyc = 0;
            #1;
            chk("rr_idle", {31'd0, s_mem.cyc}, 32'd0);
        end

        // reset mid-ACTIVE after a DMA grant
        m_dma.cyc = 1; m_dma.addr = 32'h0000_0040;
        tick();
        chk("t6_active", {31'd0, s_mem.cyc}, 32'd1);
        rst_n = 0;
        tick();
        chk("t6_cyc_drop", {29'd0, s_mem.cyc, m_dma.ack, m_mmu.ack}, 32'd0);
        chk("t6_erraddr_clr", err_addr, 32'd0);
        rst_n = 1;
        m_mmu.cyc = 1; m_mmu.addr = 32'h0000_0100;
        tick();
        chk("t6_dma_first", s_mem.addr, 32'h0000_0040);
        s_mem.ack = 1;
        #1;
        chk("t6_dma_ack", {30'd0, m_dma.ack, m_mmu.ack}, 32'd2);
        tick();
        m_dma.cyc = 0; m_mmu.cyc = 0; s_mem.ack = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
